// File: rtl/reg_bank_mux.sv
// reg_bank_mux: NUM_REGS x WIDTH register bank with one write port and two
// registered read ports. The read ports bypass a same-cycle write. A DUMP mode
// streams every register out on port A, one word per cycle.
module reg_bank_mux #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int ZERO_R0  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wrEnable,
  input  logic [SEL_W-1:0] wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEnable,
  input  logic [SEL_W-1:0] rdSelA,
  input  logic [SEL_W-1:0] rdSelB,
  input  logic             dumpStart,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic             outValid,
  output logic [SEL_W-1:0] dumpIndex,
  output logic             dumpBusy,
  output logic             dumpDone
);

  typedef enum logic {S_IDLE, S_DUMP} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic [WIDTH-1:0] r_outA, r_outB;
  logic             r_outValid, r_dumpDone;
  logic [SEL_W-1:0] r_dumpIndex, r_idx;
  logic             w_wr_ok, w_idx_last;
  logic [WIDTH-1:0] w_vA, w_vB, w_vD;

  // Read value of one select. Out-of-range selects and a hardwired R0 read as
  // zero; a write landing on the same address this cycle wins over the bank.
  function automatic logic [WIDTH-1:0] f_rd(
    input logic [SEL_W-1:0] s,
    input logic [WIDTH-1:0] rv,
    input logic             wok,
    input logic [SEL_W-1:0] wa,
    input logic [WIDTH-1:0] wd
  );
    if (int'(s) >= NUM_REGS || (ZERO_R0 != 0 && s == '0)) return '0;
    if (wok && wa == s) return wd;
    return rv;
  endfunction

  // A write is dropped when it targets a missing register or the fixed R0.
  assign w_wr_ok = wrEnable && (int'(wrAddr) < NUM_REGS) &&
                   !(ZERO_R0 != 0 && wrAddr == '0);

  assign w_vA = f_rd(rdSelA, r_regs[rdSelA], w_wr_ok, wrAddr, wrData);
  assign w_vB = f_rd(rdSelB, r_regs[rdSelB], w_wr_ok, wrAddr, wrData);
  assign w_vD = f_rd(r_idx,  r_regs[r_idx],  w_wr_ok, wrAddr, wrData);

  // The dump counter stops at the last register, never wrapping.
  assign w_idx_last = (r_idx == SEL_W'(NUM_REGS - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: a dump begins on dumpStart and ends once the last index loads.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (dumpStart) w_state_nxt = S_DUMP;
      S_DUMP: if (w_idx_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register bank write; writes are accepted in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wrAddr] <= wrData;
    end
  end

  // Output registers and dump counter. In IDLE dumpStart beats rdEnable.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_outA      <= '0;
      r_outB      <= '0;
      r_outValid  <= 1'b0;
      r_dumpIndex <= '0;
      r_dumpDone  <= 1'b0;
      r_idx       <= '0;
    end else begin
      r_dumpDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dumpStart) begin
            r_idx       <= '0;
            r_dumpIndex <= '0;
            r_outValid  <= 1'b0;
          end else if (rdEnable) begin
            r_outA     <= w_vA;
            r_outB     <= w_vB;
            r_outValid <= 1'b1;
          end else begin
            r_outValid <= 1'b0;
          end
        end
        S_DUMP: begin
          r_outA      <= w_vD;
          r_outB      <= '0;
          r_outValid  <= 1'b1;
          r_dumpIndex <= r_idx;
          if (w_idx_last) r_dumpDone <= 1'b1;
          else            r_idx      <= r_idx + 1'b1;
        end
        default: r_outValid <= 1'b0;
      endcase
    end
  end

  assign outA      = r_outA;
  assign outB      = r_outB;
  assign outValid  = r_outValid;
  assign dumpIndex = r_dumpIndex;
  assign dumpDone  = r_dumpDone;
  // Busy covers the whole DUMP state and the cycle carrying the last word.
  assign dumpBusy  = (r_state == S_DUMP) || r_dumpDone;

endmodule
